// File: rtl/multi_dataflow_engine_mc.sv
// Job-level dataflow wrapper around a streaming kernel: gates N_IN input and N_OUT
// output streams, counts output beats per channel and sequences IDLE/RUN/DONE.
module multi_dataflow_engine_mc #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int ID_W   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_mode_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [ID_W-1:0]         cfg_id_i,
  input  logic [CNT_W-1:0]        len_i,
  input  logic [N_IN-1:0]         in_valid_i,
  output logic [N_IN-1:0]         in_ready_o,
  input  logic [N_IN*DATA_W-1:0]  in_data_i,
  output logic [N_OUT-1:0]        out_valid_o,
  input  logic [N_OUT-1:0]        out_ready_i,
  output logic [N_OUT*DATA_W-1:0] out_data_o,
  output logic [N_OUT*DATA_W/8-1:0] out_strb_o,
  output logic [N_IN-1:0]         k_in_valid_o,
  input  logic [N_IN-1:0]         k_in_ready_i,
  output logic [N_IN*DATA_W-1:0]  k_in_data_o,
  input  logic [N_OUT-1:0]        k_out_valid_i,
  output logic [N_OUT-1:0]        k_out_ready_o,
  input  logic [N_OUT*DATA_W-1:0] k_out_data_i,
  output logic                    k_start_o,
  output logic [ID_W-1:0]         k_id_o,
  input  logic                    k_done_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic                    busy_o,
  output logic [N_OUT*CNT_W-1:0]  cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [ID_W-1:0]  id_reg;
  logic [CNT_W-1:0] len_reg;
  logic [CNT_W-1:0] cnt_reg [N_OUT];
  logic             done_seen_reg;
  logic             k_start_reg;
  logic             ready_reg;
  logic             run;
  logic             start_ok;
  logic             all_full;
  logic [N_OUT-1:0] open_ch;
  logic [N_OUT-1:0] fire;
  logic             unused_test_mode;

  assign unused_test_mode = test_mode_i;

  assign run      = (state_reg == S_RUN);
  assign start_ok = (state_reg == S_IDLE) && start_i && !clear_i;

  assign k_in_valid_o = run ? in_valid_i   : '0;
  assign in_ready_o   = run ? k_in_ready_i : '0;
  assign k_in_data_o  = in_data_i;
  assign out_data_o   = k_out_data_i;
  assign out_strb_o   = '1;

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
      // A channel closes once it has delivered len beats, so extra kernel beats stall.
      assign open_ch[gi]                 = run && (cnt_reg[gi] < len_reg);
      assign out_valid_o[gi]             = open_ch[gi] & k_out_valid_i[gi];
      assign k_out_ready_o[gi]           = open_ch[gi] & out_ready_i[gi];
      assign fire[gi]                    = out_valid_o[gi] & out_ready_i[gi];
      assign cnt_o[gi*CNT_W +: CNT_W]    = cnt_reg[gi];
    end
  endgenerate

  always_comb begin
    all_full = 1'b1;
    for (int c = 0; c < N_OUT; c++) begin
      if (cnt_reg[c] != len_reg) all_full = 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_i) state_next = S_RUN;
      S_RUN:   if (all_full && (done_seen_reg || k_done_i)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (clear_i) state_next = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= S_IDLE;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_reg == S_IDLE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_reg        <= '0;
      len_reg       <= '0;
      done_seen_reg <= 1'b0;
      k_start_reg   <= 1'b0;
      for (int c = 0; c < N_OUT; c++) cnt_reg[c] <= '0;
    end else begin
      k_start_reg <= start_ok;
      if (clear_i) begin
        id_reg        <= '0;
        done_seen_reg <= 1'b0;
        for (int c = 0; c < N_OUT; c++) cnt_reg[c] <= '0;
      end else if (start_ok) begin
        id_reg        <= cfg_id_i;
        len_reg       <= len_i;
        done_seen_reg <= 1'b0;
        for (int c = 0; c < N_OUT; c++) cnt_reg[c] <= '0;
      end else if (run) begin
        if (k_done_i) done_seen_reg <= 1'b1;
        for (int c = 0; c < N_OUT; c++) begin
          if (fire[c]) cnt_reg[c] <= cnt_reg[c] + CNT_W'(1);
        end
      end
    end
  end

  assign k_start_o = k_start_reg;
  assign k_id_o    = id_reg;
  assign ready_o   = ready_reg;
  assign busy_o    = run;
  assign done_o    = (state_reg == S_DONE);

endmodule
